// File: rtl/adpll_lock_seq.sv
// ADPLL lock sequencer: applies M under RESET, waits for a stable synced LOCK, retries on timeout.
// Build option ADPLL_SEQ_AUTORELOCK_EN: re-acquire automatically on LOCK loss instead of failing.
module adpll_lock_seq #(
  parameter int RST_CYCLES  = 8,
  parameter int LOCK_STABLE = 16,
  parameter int TIMEOUT     = 4096,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] req_m,
  output logic       ack,
  output logic       busy,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [2:0] pll_m,
  output logic       locked,
  output logic       fail,
  output logic [2:0] attempt,
  output logic       lock_lost
);

  // state   | meaning
  // IDLE    | no request yet, PLL held in reset
  // APPLY   | M driven, RESET held for RST_CYCLES
  // ACQUIRE | RESET released, waiting for synced LOCK
  // SETTLE  | LOCK seen, counting consecutive high cycles
  // LOCKED  | stable lock reached
  // FAIL    | retries exhausted or lock lost, PLL held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_ACQUIRE, S_SETTLE, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]       ATT_MAX   = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync1_q, lock_s_q;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             pll_reset_q, pll_reset_d;
  logic [2:0]       pll_m_q, pll_m_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic [2:0]       attempt_q, attempt_d;
  logic             lock_lost_q, lock_lost_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    pll_m_d     = pll_m_q;
    attempt_d   = attempt_q;
    lock_lost_d = lock_lost_q;
    ack_d       = 1'b0;

    if (req && (state_q == S_IDLE || state_q == S_LOCKED || state_q == S_FAIL)) begin
      ack_d       = 1'b1;
      pll_m_d     = req_m;
      attempt_d   = 3'd0;
      lock_lost_d = 1'b0;
      cnt_d       = '0;
      stab_d      = '0;
      state_d     = S_APPLY;
    end else begin
      unique case (state_q)
        S_APPLY: begin
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            state_d = S_ACQUIRE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // stab is zero in ACQUIRE, so one rule covers both states and a stable lock beats timeout
        S_ACQUIRE, S_SETTLE: begin
          cnt_d = cnt_inc;
          if (lock_s_q && stab_q == STAB_LAST) begin
            stab_d  = '0;
            state_d = S_LOCKED;
          end else if (cnt_q == TMO_LAST) begin
            stab_d = '0;
            if (attempt_q < ATT_MAX) begin
              attempt_d = attempt_q + 3'd1;
              cnt_d     = '0;
              state_d   = S_APPLY;
            end else begin
              state_d = S_FAIL;
            end
          end else if (lock_s_q) begin
            stab_d  = stab_q + CNT_W'(1);
            state_d = S_SETTLE;
          end else begin
            stab_d  = '0;
            state_d = S_ACQUIRE;
          end
        end
        S_LOCKED: begin
          if (!lock_s_q) begin
            lock_lost_d = 1'b1;
`ifdef ADPLL_SEQ_AUTORELOCK_EN
            attempt_d = 3'd0;
            cnt_d     = '0;
            stab_d    = '0;
            state_d   = S_APPLY;
`else
            state_d = S_FAIL;
`endif
          end
        end
        S_IDLE, S_FAIL: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d      = (state_d == S_APPLY) || (state_d == S_ACQUIRE) || (state_d == S_SETTLE);
    pll_reset_d = (state_d == S_IDLE) || (state_d == S_APPLY) || (state_d == S_FAIL);
    locked_d    = (state_d == S_LOCKED);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stab_q      <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      pll_m_q     <= 3'd0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      attempt_q   <= 3'd0;
      lock_lost_q <= 1'b0;
    end else begin
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      pll_reset_q <= pll_reset_d;
      pll_m_q     <= pll_m_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      attempt_q   <= attempt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign pll_reset = pll_reset_q;
  assign pll_m     = pll_m_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign attempt   = attempt_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_adpll_lock_seq.sv
// Bench for adpll_lock_seq: directed scenarios plus random req/LOCK traffic against a mode-level model.
module tb_adpll_lock_seq;
  localparam int RST_CYCLES  = 8;
  localparam int LOCK_STABLE = 16;
  localparam int TIMEOUT     = 4096;
  localparam int MAX_RETRY   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [2:0] req_m = 3'd0;
  logic       pll_lock = 1'b0;
  logic       ack, busy, pll_reset, locked, fail, lock_lost;
  logic [2:0] pll_m, attempt;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  adpll_lock_seq dut (
    .clk(clk), .reset(reset), .req(req), .req_m(req_m), .ack(ack), .busy(busy),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_m(pll_m), .locked(locked),
    .fail(fail), .attempt(attempt), .lock_lost(lock_lost)
  );

  // Model: the ACQUIRE/SETTLE pair is one lock window with elapsed time and current high-run length.
  localparam int MD_IDLE = 0, MD_APPLY = 1, MD_WIN = 2, MD_LOCKED = 3, MD_FAIL = 4;
  int         m_mode = MD_IDLE;
  int         m_left = 0, m_elapsed = 0, m_run = 0;
  bit         m_ack = 1'b0, m_lost = 1'b0;
  logic [2:0] m_pm = 3'd0, m_att = 3'd0;
  bit         h1 = 1'b0, h2 = 1'b0;

  task model_clear();
    m_mode = MD_IDLE; m_left = 0; m_elapsed = 0; m_run = 0;
    m_ack = 1'b0; m_lost = 1'b0; m_pm = 3'd0; m_att = 3'd0; h1 = 1'b0; h2 = 1'b0;
  endtask

  task model_step();
    bit ls;
    ls = h2; h2 = h1; h1 = pll_lock;
    m_ack = 1'b0;
    if (req && (m_mode == MD_IDLE || m_mode == MD_LOCKED || m_mode == MD_FAIL)) begin
      m_ack = 1'b1; m_pm = req_m; m_att = 3'd0; m_lost = 1'b0;
      m_mode = MD_APPLY; m_left = RST_CYCLES;
    end else begin
      case (m_mode)
        MD_APPLY: begin
          m_left--;
          if (m_left == 0) begin m_mode = MD_WIN; m_elapsed = 0; m_run = 0; end
        end
        MD_WIN: begin
          m_elapsed++;
          m_run = ls ? m_run + 1 : 0;
          if (m_run == LOCK_STABLE) m_mode = MD_LOCKED;
          else if (m_elapsed == TIMEOUT) begin
            if (int'(m_att) < MAX_RETRY) begin
              m_att = m_att + 3'd1; m_mode = MD_APPLY; m_left = RST_CYCLES;
            end else m_mode = MD_FAIL;
          end
        end
        MD_LOCKED: begin
          if (!ls) begin
            m_lost = 1'b1;
`ifdef ADPLL_SEQ_AUTORELOCK_EN
            m_att = 3'd0; m_mode = MD_APPLY; m_left = RST_CYCLES;
`else
            m_mode = MD_FAIL;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [11:0] act, exp;
      act = {ack, busy, pll_reset, pll_m, locked, fail, attempt, lock_lost};
      exp = {m_ack, (m_mode == MD_APPLY || m_mode == MD_WIN),
             (m_mode == MD_IDLE || m_mode == MD_APPLY || m_mode == MD_FAIL), m_pm,
             (m_mode == MD_LOCKED), (m_mode == MD_FAIL), m_att, m_lost};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL cycle_compare @%0t: dut {ack,busy,rst,m,lk,fl,att,lost}=%b model requires %b",
                 $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic request(input logic [2:0] m, input string name);
    int k;
    req_m = m; req = 1'b1; k = 0;
    while (!ack && k < 20000) begin @(negedge clk); k++; end
    check(name, int'(ack), 1);
    req = 1'b0;
  endtask

  initial begin
    int k, n, acks;
    bit saw_locked;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_pll_reset", int'(pll_reset), 1);
    reset = 1'b1;

    // T1: idle after reset release
    repeat (100) @(negedge clk);
    check("t1_pll_reset", int'(pll_reset), 1);
    check("t1_status", int'({ack, busy, locked, fail, lock_lost}), 0);
    check("t1_attempt", int'(attempt), 0);

    // T2: accept M=3, LOCK rises 50 cycles after RESET release
    req_m = 3'd3; req = 1'b1; k = 0;
    while (!ack && k < 50) begin @(negedge clk); k++; end
    check("t2_ack_latency", k, 1);
    req = 1'b0;
    check("t2_pll_m", int'(pll_m), 3);
    n = 0;
    while (pll_reset && n < 100) begin n++; @(negedge clk); end
    check("t2_reset_width", n, RST_CYCLES);
    k = 0;
    while (!locked && k < 200) begin
      if (k == 50) pll_lock = 1'b1;
      @(negedge clk); k++;
    end
    check("t2_lock_time", k, 50 + 2 + LOCK_STABLE);
    check("t2_attempt", int'(attempt), 0);

    // T4: LOCK drop while locked
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_lost_not_yet", int'(lock_lost), 0);
    @(negedge clk);
    check("t4_lock_lost", int'(lock_lost), 1);
    check("t4_pll_reset", int'(pll_reset), 1);
`ifdef ADPLL_SEQ_AUTORELOCK_EN
    check("t4_busy", int'(busy), 1);
    n = 0;
    while (pll_reset && n < 100) begin n++; @(negedge clk); end
    check("t4_relock_reset_width", n, RST_CYCLES);
    pll_lock = 1'b1; k = 0;
    while (!locked && k < 200) begin @(negedge clk); k++; end
    check("t4_relocked", int'(locked), 1);
    pll_lock = 1'b0;
`else
    check("t4_fail", int'(fail), 1);
    check("t4_locked", int'(locked), 0);
`endif

    // T5: request held during ACQUIRE is deferred until LOCKED
    request(3'd2, "t5_first_ack");
    check("t5_lost_cleared", int'(lock_lost), 0);
    k = 0;
    while (pll_reset && k < 100) begin @(negedge clk); k++; end
    req_m = 3'd6; req = 1'b1; acks = 0;
    repeat (30) begin @(negedge clk); acks += int'(ack); end
    check("t5_no_ack_busy", acks, 0);
    pll_lock = 1'b1; saw_locked = 1'b0; k = 0;
    while (!ack && k < 200) begin
      if (locked) saw_locked = 1'b1;
      @(negedge clk); k++;
    end
    req = 1'b0;
    check("t5_ack_after_locked", int'(saw_locked && ack), 1);
    check("t5_new_m", int'(pll_m), 6);

    // T6: asynchronous reset mid-SETTLE
    k = 0;
    while (pll_reset && k < 100) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    check("t6_busy_before", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_pll_reset_async", int'(pll_reset), 1);
    check("t6_locked_busy", int'({locked, busy}), 0);
    check("t6_m_attempt", int'({pll_m, attempt}), 0);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // T3: LOCK toggling every 10 cycles never settles -> all retries then FAIL
    request(3'd1, "t3_ack");
    k = 0;
    while (!fail && k < 20000) begin
      if (k % 10 == 0) pll_lock = ~pll_lock;
      @(negedge clk); k++;
    end
    check("t3_fail_time", k, (MAX_RETRY + 1) * (RST_CYCLES + TIMEOUT));
    check("t3_attempt", int'(attempt), MAX_RETRY);
    check("t3_pll_reset", int'(pll_reset), 1);
    pll_lock = 1'b0;

    // Random traffic: LOCK patterns by segment, sporadic requests held until ack
    for (int seg = 0; seg < 60; seg++) begin
      int mode, len;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(150, 500);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (req && ack) req = 1'b0;
        else if (!req && $urandom_range(0, 199) == 0) begin
          req_m = 3'($urandom_range(0, 7));
          req = 1'b1;
        end
        case (mode)
          0: pll_lock = 1'b1;
          1: pll_lock = 1'b0;
          2: if ($urandom_range(0, 3) == 0) pll_lock = ~pll_lock;
          default: if (c % 20 == 0) pll_lock = ~pll_lock;
        endcase
      end
    end
    req = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
